shift_reg_seq: RTL and testbench

//  Parametrised multi-op shift register: LOAD, logical/arithmetic shifts and rotates.

---
 rtl/shift_reg_pkg.sv | 33 +++
 rtl/shift_reg_step.sv | 53 +++++
 rtl/shift_reg_seq.sv | 147 ++++++++++++++
 tb/tb_shift_reg_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// ============================================================================
// Module   : shift_reg_pkg
// Brief    : Op codes, FSM states and helpers shared by the shift register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_step.sv
// ============================================================================
// Module   : shift_reg_step
// Brief    : Combinational single-bit step of a shift/rotate op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             si_i,
  output logic [WIDTH-1:0] next_p_o,
  output logic             so_o
);

  always_comb begin
    next_p_o = p_i;
    so_o     = 1'b0;
    case (op_e'(op_i))
      OP_SHL: begin
        next_p_o = {p_i[WIDTH-2:0], si_i};
        so_o     = p_i[WIDTH-1];
      end
      OP_SHR: begin
        next_p_o = {si_i, p_i[WIDTH-1:1]};
        so_o     = p_i[0];
      end
      OP_ROL: begin
        next_p_o = {p_i[WIDTH-2:0], p_i[WIDTH-1]};
        so_o     = p_i[WIDTH-1];
      end
      OP_ROR: begin
        next_p_o = {p_i[0], p_i[WIDTH-1:1]};
        so_o     = p_i[0];
      end
      OP_ASR: begin
        next_p_o = {p_i[WIDTH-1], p_i[WIDTH-1:1]};
        so_o     = p_i[0];
      end
      default: begin
        next_p_o = p_i;
        so_o     = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_reg_seq.sv
// ============================================================================
// Module   : shift_reg_seq
// Brief    : Multi-cycle LOAD/shift/rotate register with valid/ready command
//            interface. Define SHIFT_REG_SEQ_ABORT_EN to add the abort_i input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       op_i,
  input  logic [AW-1:0]    amt_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic             si_i,
`ifdef SHIFT_REG_SEQ_ABORT_EN
  input  logic             abort_i,
`endif
  output logic [WIDTH-1:0] p_o,
  output logic             so_o,
  output logic             so_valid_o,
  output logic             done_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             done_q, done_d;

  logic             w_accept;
  logic             w_start_shift;
  logic             w_abort;
  logic [WIDTH-1:0] w_step_p;
  logic             w_step_so;

`ifdef SHIFT_REG_SEQ_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  assign cmd_ready_o   = (state_q == IDLE) && !rst;
  assign w_accept      = cmd_valid_i && cmd_ready_o;
  assign w_start_shift = w_accept && is_shift_op(op_e'(op_i)) && (amt_i != '0);

  shift_reg_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i     (op_q),
    .p_i      (p_q),
    .si_i     (si_i),
    .next_p_o (w_step_p),
    .so_o     (w_step_so)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_start_shift) state_d = SHIFT;
      SHIFT:   if (w_abort || (rem_q == AW'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done_d is raised on the final step edge so the pulse lines up with the return to IDLE.
  always_comb begin
    p_d        = p_q;
    so_d       = so_q;
    so_valid_d = 1'b0;
    done_d     = 1'b0;
    rem_d      = rem_q;
    op_d       = op_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (op_e'(op_i) == OP_LOAD) begin
            p_d    = par_i;
            done_d = 1'b1;
          end else if (w_start_shift) begin
            rem_d = amt_i;
            op_d  = op_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (w_abort) begin
          done_d = 1'b1;
        end else begin
          p_d        = w_step_p;
          so_d       = w_step_so;
          so_valid_d = 1'b1;
          rem_d      = rem_q - AW'(1);
          done_d     = (rem_q == AW'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q        <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rem_q      <= '0;
      op_q       <= OP_NOP;
    end else begin
      p_q        <= p_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      done_q     <= done_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
    end
  end

  assign p_o        = p_q;
  assign so_o       = so_q;
  assign so_valid_o = so_valid_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_seq.sv
// ============================================================================
// Module   : tb_shift_reg_seq
// Brief    : Self-checking bench for shift_reg_seq (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_seq;
  import shift_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int AW    = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [2:0]       op_i;
  logic [AW-1:0]    amt_i;
  logic [WIDTH-1:0] par_i;
  logic             si_i;
`ifdef SHIFT_REG_SEQ_ABORT_EN
  logic             abort_i;
`endif
  logic [WIDTH-1:0] p_o;
  logic             so_o;
  logic             so_valid_o;
  logic             done_o;
  logic             busy_o;

  shift_reg_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .op_i        (op_i),
    .amt_i       (amt_i),
    .par_i       (par_i),
    .si_i        (si_i),
`ifdef SHIFT_REG_SEQ_ABORT_EN
    .abort_i     (abort_i),
`endif
    .p_o         (p_o),
    .so_o        (so_o),
    .so_valid_o  (so_valid_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       is_done;
    logic [7:0] p;
    logic       so;
    int         lat;
  } exp_t;

  typedef struct {
    op_e           op;
    logic [AW-1:0] amt;
    logic [7:0]    par;
    logic          si;
    logic [7:0]    exp_p;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[12];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         acc_cyc  = 0;
  int         busy_cnt = 0;
  logic [7:0] m        = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model of one step; returns the bit shifted out.
  function automatic logic model_step(input op_e op, input logic si, inout logic [7:0] r);
    logic so;
    so = 1'b0;
    case (op)
      OP_SHL: begin so = r[7]; r = {r[6:0], si};   end
      OP_SHR: begin so = r[0]; r = {si, r[7:1]};   end
      OP_ROL: begin so = r[7]; r = {r[6:0], r[7]}; end
      OP_ROR: begin so = r[0]; r = {r[0], r[7:1]}; end
      OP_ASR: begin so = r[0]; r = {r[7], r[7:1]}; end
      default: ;
    endcase
    return so;
  endfunction

  task automatic push_step(input op_e op, input logic si);
    exp_t e;
    e.so      = model_step(op, si, m);
    e.is_done = 1'b0;
    e.p       = m;
    e.lat     = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int lat);
    exp_t e;
    e.is_done = 1'b1;
    e.p       = m;
    e.so      = 1'b0;
    e.lat     = lat;
    exp_q.push_back(e);
  endtask

  // Scoreboard: pops one record per so_valid_o step and one per done_o pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy_o === 1'b1) busy_cnt++;
    if (so_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_step", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("step_kind", {31'd0, e.is_done}, 32'd0);
        check("step_p", {24'd0, p_o}, {24'd0, e.p});
        check("step_so", {31'd0, so_o}, {31'd0, e.so});
      end
    end
    if (done_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("done_kind", {31'd0, e.is_done}, 32'd1);
        check("done_p", {24'd0, p_o}, {24'd0, e.p});
        check("done_latency", cyc - acc_cyc, e.lat);
        check("done_ready", {31'd0, cmd_ready_o}, 32'd1);
      end
    end
  end

  task automatic issue(input op_e op, input logic [AW-1:0] amt, input logic [7:0] par,
                       input logic si, input bit push);
    int tries;
    tries = 0;
    @(negedge clk);
    while (cmd_ready_o !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (cmd_ready_o !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    op_i        = op;
    amt_i       = amt;
    par_i       = par;
    si_i        = si;
    cmd_valid_i = 1'b1;
    busy_cnt    = 0;
    if (push) begin
      if (op == OP_LOAD) begin
        m = par;
        push_done(0);
      end else if (is_shift_op(op) && amt != '0) begin
        for (int i = 0; i < int'(amt); i++) push_step(op, si);
        push_done(int'(amt));
      end else begin
        push_done(0);
      end
    end
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (exp_q.size() != 0 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_LOAD, 4'd0, 8'hA5, 1'b0, 8'hA5};
    vecs[1]  = '{OP_LOAD, 4'd0, 8'h3C, 1'b0, 8'h3C};
    vecs[2]  = '{OP_LOAD, 4'd0, 8'hA5, 1'b0, 8'hA5};
    vecs[3]  = '{OP_SHL,  4'd3, 8'h00, 1'b1, 8'h2F};
    vecs[4]  = '{OP_LOAD, 4'd0, 8'h90, 1'b0, 8'h90};
    vecs[5]  = '{OP_ASR,  4'd2, 8'h00, 1'b0, 8'hE4};
    vecs[6]  = '{OP_NOP,  4'd3, 8'hFF, 1'b1, 8'hE4};
    vecs[7]  = '{OP_SHL,  4'd0, 8'hFF, 1'b1, 8'hE4};
    vecs[8]  = '{OP_RSVD, 4'd3, 8'hFF, 1'b1, 8'hE4};
    vecs[9]  = '{OP_SHR,  4'd4, 8'h00, 1'b1, 8'hFE};
    vecs[10] = '{OP_ROL,  4'd3, 8'h00, 1'b0, 8'hF7};
    vecs[11] = '{OP_SHL,  4'd9, 8'h00, 1'b0, 8'h00};

    rst         = 1'b1;
    cmd_valid_i = 1'b1;
    op_i        = OP_LOAD;
    amt_i       = '0;
    par_i       = 8'hFF;
    si_i        = 1'b0;
`ifdef SHIFT_REG_SEQ_ABORT_EN
    abort_i     = 1'b0;
`endif

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_p", {24'd0, p_o}, 32'h00);
      check("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
    end
    rst         = 1'b0;
    cmd_valid_i = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, cmd_ready_o}, 32'd1);
    m = 8'h00;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].par, vecs[i].si, 1'b1);
      drain();
      check("final_p", {24'd0, p_o}, {24'd0, vecs[i].exp_p});
      check("busy_cycles", busy_cnt,
            (is_shift_op(vecs[i].op) && vecs[i].amt != '0) ? int'(vecs[i].amt) : 0);
    end

    // ROR by WIDTH+1 with stray commands offered while busy.
    issue(OP_LOAD, 4'd0, 8'h81, 1'b0, 1'b1);
    drain();
    issue(OP_ROR, 4'd9, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_i        = OP_LOAD;
      par_i       = 8'hFF;
      cmd_valid_i = 1'b1;
      @(negedge clk);
      cmd_valid_i = 1'b0;
    end
    drain();
    check("ror9_p", {24'd0, p_o}, 32'hC0);
    check("ror9_busy", busy_cnt, 32'd9);

    // Reset in the middle of a shift: two steps happen, then no done.
    issue(OP_LOAD, 4'd0, 8'h5A, 1'b0, 1'b1);
    drain();
    issue(OP_SHL, 4'd5, 8'h00, 1'b1, 1'b0);
    push_step(OP_SHL, 1'b1);
    push_step(OP_SHL, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_p", {24'd0, p_o}, 32'h00);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    m   = 8'h00;
    repeat (6) @(negedge clk);
    check("midrst_pending", exp_q.size(), 32'd0);
    exp_q.delete();

`ifdef SHIFT_REG_SEQ_ABORT_EN
    issue(OP_LOAD, 4'd0, 8'h01, 1'b0, 1'b1);
    drain();
    issue(OP_SHL, 4'd5, 8'h00, 1'b0, 1'b0);
    push_step(OP_SHL, 1'b0);
    push_step(OP_SHL, 1'b0);
    push_done(3);
    @(posedge clk);
    @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    drain();
    check("abort_p", {24'd0, p_o}, 32'h04);
    check("abort_idle", {31'd0, busy_o}, 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
